id_ex_reg: RTL and testbench

- Pipeline register between the decode/hazard-forwarding stage and the execute stage.
- Captures forwarded operands and decoded control fields each cycle.
- Inserts a bubble on a load-use stall request, and kills the entry on flush from EX.
- Holds its contents when the downstream stage stalls.
- Exports its own destination, write-enable and load type back to the hazard logic.
- Keeps saturating bubble and flush event counters for performance analysis.

---
 rtl/id_ex_reg.sv | 227 ++++++++++++++++++++++
 tb/tb_id_ex_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures forwarded operands and decoded controls,
// inserts bubbles on load-use hazards, dies on EX flush, holds on EX stall.
module id_ex_reg #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int LD_TYPE_WIDTH = 3,
    parameter int ST_TYPE_WIDTH = 2,
    parameter int ALU_OP_WIDTH  = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Decode_Valid,
    input  logic [DATA_WIDTH-1:0]    Decode_Pc,
    input  logic [DATA_WIDTH-1:0]    Decode_Imm,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs1Addr,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_Rs2Addr,
    input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs1Data,
    input  logic [DATA_WIDTH-1:0]    DecodeHazard_Rs2Data,
    input  logic [RF_ADDR_WIDTH-1:0] Decode_RdAddr,
    input  logic                     Decode_WbRdEn,
    input  logic [LD_TYPE_WIDTH-1:0] Decode_LdType,
    input  logic [ST_TYPE_WIDTH-1:0] Decode_StType,
    input  logic [ALU_OP_WIDTH-1:0]  Decode_AluOp,
    input  logic                     DecodeHazard_StallReq,
    input  logic                     EX_Flush,
    input  logic                     EX_StallReq,
    output logic                     IDEX_Valid,
    output logic [DATA_WIDTH-1:0]    IDEX_Pc,
    output logic [DATA_WIDTH-1:0]    IDEX_Imm,
    output logic [DATA_WIDTH-1:0]    IDEX_Rs1Data,
    output logic [DATA_WIDTH-1:0]    IDEX_Rs2Data,
    output logic [RF_ADDR_WIDTH-1:0] IDEX_Rs1Addr,
    output logic [RF_ADDR_WIDTH-1:0] IDEX_Rs2Addr,
    output logic [RF_ADDR_WIDTH-1:0] IDEX_RdAddr,
    output logic                     IDEX_WbRdEn,
    output logic [LD_TYPE_WIDTH-1:0] IDEX_LdType,
    output logic [ST_TYPE_WIDTH-1:0] IDEX_StType,
    output logic [ALU_OP_WIDTH-1:0]  IDEX_AluOp,
    output logic                     IDEX_HoldReq,
    output logic [CNT_WIDTH-1:0]     IDEX_BubbleCnt,
    output logic [CNT_WIDTH-1:0]     IDEX_FlushCnt
);

    typedef enum logic [2:0] {
        ACT_RESET  = 3'd0,
        ACT_FLUSH  = 3'd1,
        ACT_HOLD   = 3'd2,
        ACT_HAZARD = 3'd3,
        ACT_LOAD   = 3'd4,
        ACT_IDLE   = 3'd5
    } action_e;

    localparam logic [DATA_WIDTH-1:0]    ZERO_DATA = {DATA_WIDTH{1'b0}};
    localparam logic [RF_ADDR_WIDTH-1:0] ZERO_ADDR = {RF_ADDR_WIDTH{1'b0}};
    localparam logic [LD_TYPE_WIDTH-1:0] LD_XXX    = {LD_TYPE_WIDTH{1'b0}};
    localparam logic [ST_TYPE_WIDTH-1:0] ST_NONE   = {ST_TYPE_WIDTH{1'b0}};
    localparam logic [ALU_OP_WIDTH-1:0]  ZERO_ALU  = {ALU_OP_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]     ZERO_CNT  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    action_e                  action_s;
    logic                     valid_d,   valid_q;
    logic [DATA_WIDTH-1:0]    pc_d,      pc_q;
    logic [DATA_WIDTH-1:0]    imm_d,     imm_q;
    logic [DATA_WIDTH-1:0]    rs1_data_d, rs1_data_q;
    logic [DATA_WIDTH-1:0]    rs2_data_d, rs2_data_q;
    logic [RF_ADDR_WIDTH-1:0] rs1_addr_d, rs1_addr_q;
    logic [RF_ADDR_WIDTH-1:0] rs2_addr_d, rs2_addr_q;
    logic [RF_ADDR_WIDTH-1:0] rd_addr_d, rd_addr_q;
    logic                     wb_rd_en_d, wb_rd_en_q;
    logic [LD_TYPE_WIDTH-1:0] ld_type_d, ld_type_q;
    logic [ST_TYPE_WIDTH-1:0] st_type_d, st_type_q;
    logic [ALU_OP_WIDTH-1:0]  alu_op_d,  alu_op_q;
    logic [CNT_WIDTH-1:0]     bubble_cnt_d, bubble_cnt_q;
    logic [CNT_WIDTH-1:0]     flush_cnt_d,  flush_cnt_q;

    // Priority decode of this cycle's action: reset > flush > EX stall > hazard > load
    always_comb begin
        action_s = ACT_IDLE;
        if (rst) begin
            action_s = ACT_RESET;
        end else if (EX_Flush) begin
            action_s = ACT_FLUSH;
        end else if (EX_StallReq) begin
            action_s = ACT_HOLD;
        end else if (DecodeHazard_StallReq) begin
            action_s = ACT_HAZARD;
        end else if (Decode_Valid) begin
            action_s = ACT_LOAD;
        end else begin
            action_s = ACT_IDLE;
        end
    end

    // Upstream is redirected rather than held while a flush is in progress
    always_comb begin
        IDEX_HoldReq = ~rst & ~EX_Flush & (EX_StallReq | DecodeHazard_StallReq);
    end

    // Next-state for the payload and the event counters
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        rs1_data_d   = rs1_data_q;
        rs2_data_d   = rs2_data_q;
        rs1_addr_d   = rs1_addr_q;
        rs2_addr_d   = rs2_addr_q;
        rd_addr_d    = rd_addr_q;
        wb_rd_en_d   = wb_rd_en_q;
        ld_type_d    = ld_type_q;
        st_type_d    = st_type_q;
        alu_op_d     = alu_op_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        case (action_s)
            ACT_HOLD: begin
                valid_d = valid_q;
            end
            ACT_LOAD: begin
                valid_d    = 1'b1;
                pc_d       = Decode_Pc;
                imm_d      = Decode_Imm;
                rs1_data_d = DecodeHazard_Rs1Data;
                rs2_data_d = DecodeHazard_Rs2Data;
                rs1_addr_d = Decode_Rs1Addr;
                rs2_addr_d = Decode_Rs2Addr;
                rd_addr_d  = Decode_RdAddr;
                wb_rd_en_d = Decode_WbRdEn;
                ld_type_d  = Decode_LdType;
                st_type_d  = Decode_StType;
                alu_op_d   = Decode_AluOp;
            end
            ACT_RESET, ACT_FLUSH, ACT_HAZARD, ACT_IDLE: begin
                // Bubble: zeroed RdAddr/WbRdEn/LdType keep the hazard unit from matching it
                valid_d    = 1'b0;
                pc_d       = ZERO_DATA;
                imm_d      = ZERO_DATA;
                rs1_data_d = ZERO_DATA;
                rs2_data_d = ZERO_DATA;
                rs1_addr_d = ZERO_ADDR;
                rs2_addr_d = ZERO_ADDR;
                rd_addr_d  = ZERO_ADDR;
                wb_rd_en_d = 1'b0;
                ld_type_d  = LD_XXX;
                st_type_d  = ST_NONE;
                alu_op_d   = ZERO_ALU;
                if (action_s == ACT_RESET) begin
                    bubble_cnt_d = ZERO_CNT;
                    flush_cnt_d  = ZERO_CNT;
                end else if (action_s == ACT_HAZARD) begin
                    bubble_cnt_d = sat_inc(bubble_cnt_q);
                end else if ((action_s == ACT_FLUSH) && valid_q) begin
                    flush_cnt_d = sat_inc(flush_cnt_q);
                end else begin
                    bubble_cnt_d = bubble_cnt_q;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            pc_q         <= ZERO_DATA;
            imm_q        <= ZERO_DATA;
            rs1_data_q   <= ZERO_DATA;
            rs2_data_q   <= ZERO_DATA;
            rs1_addr_q   <= ZERO_ADDR;
            rs2_addr_q   <= ZERO_ADDR;
            rd_addr_q    <= ZERO_ADDR;
            wb_rd_en_q   <= 1'b0;
            ld_type_q    <= LD_XXX;
            st_type_q    <= ST_NONE;
            alu_op_q     <= ZERO_ALU;
            bubble_cnt_q <= ZERO_CNT;
            flush_cnt_q  <= ZERO_CNT;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            rs1_addr_q   <= rs1_addr_d;
            rs2_addr_q   <= rs2_addr_d;
            rd_addr_q    <= rd_addr_d;
            wb_rd_en_q   <= wb_rd_en_d;
            ld_type_q    <= ld_type_d;
            st_type_q    <= st_type_d;
            alu_op_q     <= alu_op_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign IDEX_Valid     = valid_q;
    assign IDEX_Pc        = pc_q;
    assign IDEX_Imm       = imm_q;
    assign IDEX_Rs1Data   = rs1_data_q;
    assign IDEX_Rs2Data   = rs2_data_q;
    assign IDEX_Rs1Addr   = rs1_addr_q;
    assign IDEX_Rs2Addr   = rs2_addr_q;
    assign IDEX_RdAddr    = rd_addr_q;
    assign IDEX_WbRdEn    = wb_rd_en_q;
    assign IDEX_LdType    = ld_type_q;
    assign IDEX_StType    = st_type_q;
    assign IDEX_AluOp     = alu_op_q;
    assign IDEX_BubbleCnt = bubble_cnt_q;
    assign IDEX_FlushCnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a 16-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream and are compared against a priority-rule model.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, d_valid, d_we, hz, fl, st;
    logic [31:0] d_pc, d_imm, d_rs1d, d_rs2d;
    logic [4:0]  d_rs1a, d_rs2a, d_rda;
    logic [2:0]  d_ld;
    logic [1:0]  d_st;
    logic [3:0]  d_alu;

    logic        o_valid, o_we, o_hold, s_valid, s_we, s_hold;
    logic [31:0] o_pc, o_imm, o_rs1d, o_rs2d, s_pc, s_imm, s_rs1d, s_rs2d;
    logic [4:0]  o_rs1a, o_rs2a, o_rda, s_rs1a, s_rs2a, s_rda;
    logic [2:0]  o_ld, s_ld;
    logic [1:0]  o_st, s_st;
    logic [3:0]  o_alu, s_alu, s_bub, s_flc;
    logic [15:0] o_bub, o_flc;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .Decode_Valid(d_valid), .Decode_Pc(d_pc), .Decode_Imm(d_imm),
        .Decode_Rs1Addr(d_rs1a), .Decode_Rs2Addr(d_rs2a), .DecodeHazard_Rs1Data(d_rs1d),
        .DecodeHazard_Rs2Data(d_rs2d), .Decode_RdAddr(d_rda), .Decode_WbRdEn(d_we),
        .Decode_LdType(d_ld), .Decode_StType(d_st), .Decode_AluOp(d_alu),
        .DecodeHazard_StallReq(hz), .EX_Flush(fl), .EX_StallReq(st),
        .IDEX_Valid(o_valid), .IDEX_Pc(o_pc), .IDEX_Imm(o_imm), .IDEX_Rs1Data(o_rs1d),
        .IDEX_Rs2Data(o_rs2d), .IDEX_Rs1Addr(o_rs1a), .IDEX_Rs2Addr(o_rs2a), .IDEX_RdAddr(o_rda),
        .IDEX_WbRdEn(o_we), .IDEX_LdType(o_ld), .IDEX_StType(o_st), .IDEX_AluOp(o_alu),
        .IDEX_HoldReq(o_hold), .IDEX_BubbleCnt(o_bub), .IDEX_FlushCnt(o_flc)
    );

    id_ex_reg #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .Decode_Valid(d_valid), .Decode_Pc(d_pc), .Decode_Imm(d_imm),
        .Decode_Rs1Addr(d_rs1a), .Decode_Rs2Addr(d_rs2a), .DecodeHazard_Rs1Data(d_rs1d),
        .DecodeHazard_Rs2Data(d_rs2d), .Decode_RdAddr(d_rda), .Decode_WbRdEn(d_we),
        .Decode_LdType(d_ld), .Decode_StType(d_st), .Decode_AluOp(d_alu),
        .DecodeHazard_StallReq(hz), .EX_Flush(fl), .EX_StallReq(st),
        .IDEX_Valid(s_valid), .IDEX_Pc(s_pc), .IDEX_Imm(s_imm), .IDEX_Rs1Data(s_rs1d),
        .IDEX_Rs2Data(s_rs2d), .IDEX_Rs1Addr(s_rs1a), .IDEX_Rs2Addr(s_rs2a), .IDEX_RdAddr(s_rda),
        .IDEX_WbRdEn(s_we), .IDEX_LdType(s_ld), .IDEX_StType(s_st), .IDEX_AluOp(s_alu),
        .IDEX_HoldReq(s_hold), .IDEX_BubbleCnt(s_bub), .IDEX_FlushCnt(s_flc)
    );

    int checks = 0;
    int fails  = 0;

    // Reference state
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d;
    logic [4:0]  m_rs1a, m_rs2a, m_rda;
    logic [2:0]  m_ld;
    logic [1:0]  m_st;
    logic [3:0]  m_alu;
    int          m_bub, m_flc, m_bub4, m_flc4;

    logic [193:0] dut_vec, exp_vec;
    assign dut_vec = {o_valid, o_pc, o_imm, o_rs1d, o_rs2d, o_rs1a, o_rs2a, o_rda, o_we,
                      o_ld, o_st, o_alu, o_bub, o_flc, s_bub, s_flc};

    function automatic logic exp_hold();
        return !rst && !fl && (st || hz);
    endfunction

    task automatic model_bubble();
        {m_valid, m_pc, m_imm, m_rs1d, m_rs2d, m_rs1a, m_rs2a, m_rda, m_we, m_ld, m_st, m_alu} = '0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_bubble();
            m_bub = 0; m_flc = 0; m_bub4 = 0; m_flc4 = 0;
        end else if (fl) begin
            if (m_valid) begin
                if (m_flc < 65535) m_flc = m_flc + 1;
                if (m_flc4 < 15) m_flc4 = m_flc4 + 1;
            end
            model_bubble();
        end else if (st) begin
            // entry and counters unchanged
        end else if (hz) begin
            model_bubble();
            if (m_bub < 65535) m_bub = m_bub + 1;
            if (m_bub4 < 15) m_bub4 = m_bub4 + 1;
        end else if (d_valid) begin
            m_valid = 1'b1; m_pc = d_pc; m_imm = d_imm; m_rs1d = d_rs1d; m_rs2d = d_rs2d;
            m_rs1a = d_rs1a; m_rs2a = d_rs2a; m_rda = d_rda; m_we = d_we;
            m_ld = d_ld; m_st = d_st; m_alu = d_alu;
        end else begin
            model_bubble();
        end
        exp_vec = {m_valid, m_pc, m_imm, m_rs1d, m_rs2d, m_rs1a, m_rs2a, m_rda, m_we,
                   m_ld, m_st, m_alu, m_bub[15:0], m_flc[15:0], m_bub4[3:0], m_flc4[3:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_inputs();
        d_pc = $urandom; d_imm = $urandom; d_rs1d = $urandom; d_rs2d = $urandom;
        d_rs1a = 5'($urandom); d_rs2a = 5'($urandom); d_rda = 5'($urandom);
        d_we = 1'($urandom); d_ld = 3'($urandom); d_st = 2'($urandom); d_alu = 4'($urandom);
        d_valid = 1'($urandom);
    endtask

    task automatic quiet_ctrl();
        rst = 1'b0; fl = 1'b0; st = 1'b0; hz = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            rst = 1'b1; st = 1'b1; hz = 1'b1; fl = 1'($urandom);
            #1;
            checks++;
            if (o_hold !== 1'b0) begin fails++; $display("FAIL reset_hold: got %b expected 0", o_hold); end
            tick();
            checks++;
            if (dut_vec !== exp_vec || dut_vec !== 194'd0) begin
                fails++; $display("FAIL reset_state: got %h expected %h", dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_load();
        rand_inputs(); quiet_ctrl();
        d_valid = 1'b1; d_pc = 32'h100; d_rs1d = 32'hDEADBEEF; d_rda = 5'd5; d_we = 1'b1; d_ld = 3'd2;
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_rs1d !== 32'hDEADBEEF || o_rda !== 5'd5 ||
            o_we !== 1'b1 || o_ld !== 3'd2) begin
            fails++; $display("FAIL load_fields: got v=%b pc=%h rs1=%h rd=%0d we=%b ld=%0d expected 1/100/deadbeef/5/1/2",
                              o_valid, o_pc, o_rs1d, o_rda, o_we, o_ld);
        end
        checks++;
        if (dut_vec !== exp_vec) begin fails++; $display("FAIL load_all: got %h expected %h", dut_vec, exp_vec); end
    endtask

    task automatic test_load_use();
        rand_inputs(); quiet_ctrl();
        d_valid = 1'b1; hz = 1'b1;
        #1;
        checks++;
        if (o_hold !== 1'b1) begin fails++; $display("FAIL loaduse_hold: got %b expected 1", o_hold); end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_we !== 1'b0 || o_ld !== 3'd0 || o_bub !== 16'd1) begin
            fails++; $display("FAIL loaduse_bubble: got v=%b we=%b ld=%0d bub=%0d expected 0/0/0/1",
                              o_valid, o_we, o_ld, o_bub);
        end
        checks++;
        if (dut_vec !== exp_vec) begin fails++; $display("FAIL loaduse_all: got %h expected %h", dut_vec, exp_vec); end
    endtask

    task automatic test_ex_stall();
        logic [15:0] bub_before;
        rand_inputs(); quiet_ctrl();
        d_valid = 1'b1; d_pc = 32'h200;
        tick();
        bub_before = o_bub;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); quiet_ctrl();
            st = 1'b1; hz = 1'b1;
            #1;
            checks++;
            if (o_hold !== 1'b1) begin fails++; $display("FAIL exstall_hold: got %b expected 1", o_hold); end
            tick();
            checks++;
            if (o_pc !== 32'h200 || o_valid !== 1'b1 || o_bub !== bub_before || dut_vec !== exp_vec) begin
                fails++; $display("FAIL exstall_keep: got pc=%h bub=%0d vec=%h expected pc=200 bub=%0d vec=%h",
                                  o_pc, o_bub, dut_vec, bub_before, exp_vec);
            end
        end
    endtask

    task automatic test_flush();
        quiet_ctrl(); rst = 1'b1; tick();
        rand_inputs(); quiet_ctrl(); d_valid = 1'b1; tick();
        rand_inputs(); quiet_ctrl(); d_valid = 1'b1; hz = 1'b1; tick();   // BubbleCnt=1
        rand_inputs(); quiet_ctrl(); d_valid = 1'b1; tick();              // valid entry
        rand_inputs(); quiet_ctrl();
        fl = 1'b1; st = 1'b1; hz = 1'b1;
        #1;
        checks++;
        if (o_hold !== 1'b0) begin fails++; $display("FAIL flush_hold: got %b expected 0", o_hold); end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_flc !== 16'd1 || o_bub !== 16'd1 || dut_vec !== exp_vec) begin
            fails++; $display("FAIL flush_kill: got v=%b flc=%0d bub=%0d expected 0/1/1", o_valid, o_flc, o_bub);
        end
        rand_inputs(); quiet_ctrl(); fl = 1'b1;
        tick();
        checks++;
        if (o_flc !== 16'd1 || dut_vec !== exp_vec) begin
            fails++; $display("FAIL flush_on_bubble: got flc=%0d expected 1", o_flc);
        end
    endtask

    task automatic test_reset_override();
        rand_inputs(); quiet_ctrl(); d_valid = 1'b1; tick();
        rand_inputs(); quiet_ctrl(); st = 1'b1; rst = 1'b1;
        tick();
        checks++;
        if (dut_vec !== 194'd0 || dut_vec !== exp_vec) begin
            fails++; $display("FAIL reset_over_hold: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 49) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            st  = ($urandom_range(0, 4) == 0);
            hz  = ($urandom_range(0, 4) == 0);
            d_valid = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (o_hold !== exp_hold() || s_hold !== exp_hold()) begin
                fails++; $display("FAIL random_hold[%0d]: got %b/%b expected %b", i, o_hold, s_hold, exp_hold());
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                fails++; $display("FAIL random_state[%0d]: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_saturation();
        quiet_ctrl(); rst = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            rand_inputs(); quiet_ctrl(); hz = 1'b1; tick();
        end
        checks++;
        if (s_bub !== 4'd15 || o_bub !== 16'd20 || dut_vec !== exp_vec) begin
            fails++; $display("FAIL sat_bubble: got %0d/%0d expected 15/20", s_bub, o_bub);
        end
        for (int i = 0; i < 20; i++) begin
            rand_inputs(); quiet_ctrl(); d_valid = 1'b1; tick();
            quiet_ctrl(); fl = 1'b1; tick();
        end
        checks++;
        if (s_flc !== 4'd15 || o_flc !== 16'd20 || dut_vec !== exp_vec) begin
            fails++; $display("FAIL sat_flush: got %0d/%0d expected 15/20", s_flc, o_flc);
        end
    endtask

    initial begin
        rand_inputs(); quiet_ctrl(); rst = 1'b1;
        m_bub = 0; m_flc = 0; m_bub4 = 0; m_flc4 = 0;
        model_bubble();
        test_reset();
        test_load();
        test_load_use();
        test_ex_stall();
        test_flush();
        test_reset_override();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
